rf_cmd_dispatch: RTL and testbench

Command dispatcher sitting directly downstream of the RS232 UART framing block in the RF control path. It consumes each 128-bit received command frame (`recieve_data`/`recirve_vld`), verifies it, executes register writes/reads on a bank of 32-bit RF configuration registers, and returns a 128-bit response frame through the UART send interface (`send_en`/`send_data`/`send_vld`). The block owns the configuration register file that drives the RF control logic.

---
 rtl/rf_cmd_dispatch.sv | 168 ++++++++++++++++
 tb/tb_rf_cmd_dispatch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_cmd_dispatch.sv
// Command dispatcher: verifies 128-bit UART command frames, executes register
// reads/writes on the RF config bank and returns a response frame.
// Optional build macro: CMD_CHECKSUM_EN enables command checksum verification.
module rf_cmd_dispatch #(
  parameter int NREG  = 8,
  parameter int TX_TO = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [127:0]         recieve_data,
  input  logic                 recirve_vld,
  input  logic                 send_vld,
  output logic                 send_en,
  output logic [127:0]         send_data,
  input  logic [31:0]          status_in,
  output logic [NREG*32-1:0]   cfg_regs,
  output logic                 cfg_wr,
  output logic [3:0]           cfg_addr,
  output logic [7:0]           drop_cnt,
  output logic                 tx_err
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int TW = $clog2(TX_TO + 1);

  localparam logic [7:0] OP_WR     = 8'hA1;
  localparam logic [7:0] OP_RD     = 8'hA2;
  localparam logic [7:0] OP_PING   = 8'hA3;
  localparam logic [7:0] ADDR_STAT = 8'h80;
  localparam logic [7:0] NREG_B    = 8'(NREG);

  localparam logic [7:0] ST_OK   = 8'h00;
  localparam logic [7:0] ST_OPC  = 8'h01;
  localparam logic [7:0] ST_ADDR = 8'h02;
  localparam logic [7:0] ST_CSUM = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_EXEC, S_SEND, S_WAIT_BUSY, S_WAIT_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [127:0]   cmd_q;
  logic [7:0]     status_q, status_d;
  logic [TW-1:0]  timer_q;
  logic [127:0]   send_data_q;
  logic           cfg_wr_q;
  logic [3:0]     cfg_addr_q;
  logic [7:0]     drop_cnt_q;
  logic [31:0]    regs_q [NREG];

  logic [7:0]  cmd_op, cmd_addr, cmd_tag;
  logic [31:0] cmd_data;
  assign cmd_op   = cmd_q[127:120];
  assign cmd_addr = cmd_q[119:112];
  assign cmd_tag  = cmd_q[111:104];
  assign cmd_data = cmd_q[31:0];

  logic csum_err;
`ifdef CMD_CHECKSUM_EN
  logic [7:0] cmd_xor;
  always_comb begin
    cmd_xor = 8'h00;
    for (int i = 0; i < 16; i++) cmd_xor ^= cmd_q[i*8 +: 8];
  end
  assign csum_err = |cmd_xor;
`else
  logic unused_fields;
  assign csum_err      = 1'b0;
  assign unused_fields = ^cmd_q[103:32];
`endif

  logic reg_hit, stat_hit, op_ok, addr_ok;
  always_comb begin
    reg_hit  = cmd_addr < NREG_B;
    stat_hit = cmd_addr == ADDR_STAT;
    op_ok    = (cmd_op == OP_WR) || (cmd_op == OP_RD) || (cmd_op == OP_PING);
    // The status word is read-only, so it is a valid target for everything but writes.
    addr_ok  = reg_hit || (stat_hit && cmd_op != OP_WR);
    if (csum_err)      status_d = ST_CSUM;
    else if (!op_ok)   status_d = ST_OPC;
    else if (!addr_ok) status_d = ST_ADDR;
    else               status_d = ST_OK;
  end

  logic         do_wr;
  logic [31:0]  rd_val, resp_data;
  logic [7:0]   resp_csum;
  always_comb begin
    do_wr     = (status_q == ST_OK) && (cmd_op == OP_WR);
    rd_val    = stat_hit ? status_in : regs_q[cmd_addr[AW-1:0]];
    resp_data = ((status_q == ST_OK) && (cmd_op == OP_RD)) ? rd_val : cmd_data;
    resp_csum = cmd_op ^ cmd_addr ^ cmd_tag ^ status_q ^ resp_data[31:24]
              ^ resp_data[23:16] ^ resp_data[15:8] ^ resp_data[7:0];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d = state_q;
    send_en = 1'b0;
    tx_err  = 1'b0;
    case (state_q)
      S_IDLE:  if (recirve_vld) state_d = S_CHECK;
      S_CHECK: state_d = S_EXEC;
      S_EXEC:  state_d = S_SEND;
      S_SEND: begin
        if (!send_vld) begin
          send_en = 1'b1;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (send_vld) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TW'(TX_TO - 1)) begin
          tx_err  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: if (!send_vld) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      status_q    <= ST_OK;
      timer_q     <= '0;
      send_data_q <= '0;
      cfg_wr_q    <= 1'b0;
      cfg_addr_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      cfg_wr_q <= (state_q == S_EXEC) && do_wr;
      timer_q  <= (state_q == S_WAIT_BUSY) ? timer_q + 1'b1 : '0;
      if (state_q == S_IDLE && recirve_vld) cmd_q <= recieve_data;
      if (state_q == S_CHECK) status_q <= status_d;
      if (state_q == S_EXEC) begin
        send_data_q <= {cmd_op, cmd_addr, cmd_tag, resp_csum, status_q, 56'h0, resp_data};
        if (do_wr) cfg_addr_q <= cmd_addr[3:0];
      end
      if (recirve_vld && state_q != S_IDLE && drop_cnt_q != 8'hFF)
        drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  // NOTE: the register file drives RF control directly, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
    end else if (state_q == S_EXEC && do_wr) begin
      regs_q[cmd_addr[AW-1:0]] <= cmd_data;
    end
  end

  always_comb begin
    for (int k = 0; k < NREG; k++) cfg_regs[k*32 +: 32] = regs_q[k];
  end

  assign send_data = send_data_q;
  assign cfg_wr    = cfg_wr_q;
  assign cfg_addr  = cfg_addr_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rf_cmd_dispatch.sv
// Scoreboard testbench for rf_cmd_dispatch; expectations track CMD_CHECKSUM_EN.
module tb_rf_cmd_dispatch;

  localparam int NREG  = 8;
  localparam int TX_TO = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [127:0]        recieve_data;
  logic                recirve_vld;
  logic                send_vld;
  logic                send_en;
  logic [127:0]        send_data;
  logic [31:0]         status_in;
  logic [NREG*32-1:0]  cfg_regs;
  logic                cfg_wr;
  logic [3:0]          cfg_addr;
  logic [7:0]          drop_cnt;
  logic                tx_err;

  rf_cmd_dispatch #(.NREG(NREG), .TX_TO(TX_TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .recieve_data (recieve_data),
    .recirve_vld  (recirve_vld),
    .send_vld     (send_vld),
    .send_en      (send_en),
    .send_data    (send_data),
    .status_in    (status_in),
    .cfg_regs     (cfg_regs),
    .cfg_wr       (cfg_wr),
    .cfg_addr     (cfg_addr),
    .drop_cnt     (drop_cnt),
    .tx_err       (tx_err)
  );

  always #10 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] exp_q [$];
  logic [127:0] last_exp;
  logic [31:0]  model_regs [NREG];
  bit           exp_wr;
  logic [3:0]   exp_waddr;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_frame(input logic [7:0] op, input logic [7:0] addr,
                                            input logic [7:0] tag, input logic [7:0] st,
                                            input logic [31:0] data, input logic [7:0] flip);
    logic [127:0] f;
    logic [7:0]   x;
    f = {op, addr, tag, 8'h00, st, 56'h0, data};
    x = 8'h00;
    for (int i = 0; i < 16; i++) x ^= f[i*8 +: 8];
    f[103:96] = x ^ flip;
    return f;
  endfunction

  function automatic logic [255:0] flat_model();
    logic [255:0] f;
    for (int k = 0; k < NREG; k++) f[k*32 +: 32] = model_regs[k];
    return f;
  endfunction

  // Called at a falling edge with the DUT idle; returns one cycle later.
  task automatic send_frame(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] tag,
                            input logic [31:0] data, input bit corrupt);
    logic [7:0]  st;
    logic [31:0] rd;
    bit          csum_bad;
    csum_bad = 1'b0;
`ifdef CMD_CHECKSUM_EN
    csum_bad = corrupt;
`endif
    if (csum_bad)                                          st = 8'h03;
    else if (op != 8'hA1 && op != 8'hA2 && op != 8'hA3)    st = 8'h01;
    else if (!(addr < NREG || (addr == 8'h80 && op != 8'hA1))) st = 8'h02;
    else                                                   st = 8'h00;
    rd     = data;
    exp_wr = 1'b0;
    if (st == 8'h00 && op == 8'hA1) begin
      model_regs[addr[2:0]] = data;
      exp_wr    = 1'b1;
      exp_waddr = addr[3:0];
    end
    if (st == 8'h00 && op == 8'hA2) rd = (addr == 8'h80) ? status_in : model_regs[addr[2:0]];
    exp_q.push_back(mk_frame(op, addr, tag, st, rd, 8'h00));
    recieve_data = mk_frame(op, addr, tag, 8'h00, data, corrupt ? 8'h55 : 8'h00);
    recirve_vld  = 1'b1;
    @(negedge clk);
    recirve_vld  = 1'b0;
  endtask

  // Waits for send_en and scores the frame; with respond=0 it returns in WAIT_BUSY.
  task automatic wait_response(input bit respond);
    int lat;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (send_en) begin
        lat = i;
        break;
      end
    end
    check("send_en_latency", 256'(lat), 256'(2));
    check("cfg_wr", 256'(cfg_wr), 256'(exp_wr));
    if (exp_wr) check("cfg_addr", 256'(cfg_addr), 256'(exp_waddr));
    last_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check("resp_frame", 256'(send_data), 256'(last_exp));
    @(negedge clk);
    check("send_en_pulse", 256'(send_en), 256'(0));
    check("cfg_wr_pulse", 256'(cfg_wr), 256'(0));
    check("cfg_regs", cfg_regs, flat_model());
    if (respond) begin
      send_vld = 1'b1;
      repeat (3) @(negedge clk);
      check("send_data_stable", 256'(send_data), 256'(last_exp));
      send_vld = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_send_en"},   256'(send_en),   256'(0));
    check({tag, "_send_data"}, 256'(send_data), 256'(0));
    check({tag, "_cfg_regs"},  cfg_regs,        256'(0));
    check({tag, "_cfg_wr"},    256'(cfg_wr),    256'(0));
    check({tag, "_cfg_addr"},  256'(cfg_addr),  256'(0));
    check({tag, "_drop_cnt"},  256'(drop_cnt),  256'(0));
    check({tag, "_tx_err"},    256'(tx_err),    256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int tx_at;
    logic [7:0] op_tab [4];

    rst_n        = 1'b0;
    recieve_data = '0;
    recirve_vld  = 1'b0;
    send_vld     = 1'b0;
    status_in    = 32'hDEADBEEF;
    for (int k = 0; k < NREG; k++) model_regs[k] = '0;
    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Reference write, read-back and status read.
    send_frame(8'hA1, 8'h03, 8'h5A, 32'h12345678, 1'b0); wait_response(1);
    send_frame(8'hA2, 8'h03, 8'h11, 32'h0,        1'b0); wait_response(1);
    send_frame(8'hA2, 8'h80, 8'h12, 32'h0,        1'b0); wait_response(1);
    // Error classes, precedence and boundaries.
    send_frame(8'h55, 8'h02, 8'h13, 32'hAAAA5555, 1'b0); wait_response(1);
    send_frame(8'hA1, 8'h80, 8'h14, 32'h0BADF00D, 1'b0); wait_response(1);
    send_frame(8'hA1, 8'h08, 8'h15, 32'h01020304, 1'b0); wait_response(1);
    send_frame(8'hA2, 8'h20, 8'h16, 32'h99999999, 1'b0); wait_response(1);
    send_frame(8'h00, 8'h40, 8'h17, 32'h77777777, 1'b0); wait_response(1);
    send_frame(8'hA3, 8'h00, 8'h18, 32'hCAFEF00D, 1'b0); wait_response(1);
    send_frame(8'hA1, 8'h07, 8'h19, 32'hFFFF0001, 1'b0); wait_response(1);
    send_frame(8'hA2, 8'h07, 8'h1A, 32'h0,        1'b0); wait_response(1);
    send_frame(8'hA1, 8'h01, 8'h1B, 32'h5EED5EED, 1'b1); wait_response(1);
    send_frame(8'h42, 8'h99, 8'h1C, 32'h00000042, 1'b1); wait_response(1);

    op_tab[0] = 8'hA1; op_tab[1] = 8'hA2; op_tab[2] = 8'hA3;
    for (int n = 0; n < 12; n++) begin
      int r;
      logic [7:0] a;
      op_tab[3] = 8'($urandom);
      r = $urandom_range(0, 9);
      a = (r == 9) ? 8'h80 : 8'(r);
      send_frame(op_tab[$urandom_range(0, 3)], a, 8'(n), $urandom, 1'b0);
      wait_response(1);
    end

    // Drops while busy, including the cycle WAIT_DONE returns to IDLE.
    send_frame(8'hA3, 8'h01, 8'h20, 32'h0000BEEF, 1'b0);
    wait_response(0);
    send_vld = 1'b1;
    @(negedge clk);
    recieve_data = mk_frame(8'hA1, 8'h02, 8'h21, 8'h00, 32'h1, 8'h00);
    recirve_vld  = 1'b1;
    @(negedge clk);
    recirve_vld  = 1'b0;
    check("drop_cnt_1", 256'(drop_cnt), 256'(1));
    @(negedge clk);
    send_vld    = 1'b0;
    recirve_vld = 1'b1;
    @(negedge clk);
    recirve_vld = 1'b0;
    check("drop_cnt_2", 256'(drop_cnt), 256'(2));
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (send_en) seen++;
    end
    check("no_extra_send", 256'(seen), 256'(0));
    check("cfg_regs_after_drop", cfg_regs, flat_model());

    send_frame(8'hA3, 8'h02, 8'h22, 32'h00000300, 1'b0);
    wait_response(0);
    send_vld = 1'b1;
    @(negedge clk);
    recirve_vld = 1'b1;
    repeat (300) @(negedge clk);
    recirve_vld = 1'b0;
    check("drop_cnt_sat", 256'(drop_cnt), 256'(255));
    send_vld = 1'b0;
    repeat (2) @(negedge clk);

    // Transmit timeout, then normal service resumes.
    send_frame(8'hA2, 8'h03, 8'h30, 32'h0, 1'b0);
    wait_response(0);
    tx_at = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (tx_err) begin
        tx_at = i + 1;
        break;
      end
    end
    check("tx_err_delay", 256'(tx_at), 256'(TX_TO));
    @(negedge clk);
    check("tx_err_pulse", 256'(tx_err), 256'(0));
    send_frame(8'hA1, 8'h06, 8'h31, 32'h600D600D, 1'b0); wait_response(1);

    // Reset while waiting for the transmitter.
    send_frame(8'hA1, 8'h05, 8'h40, 32'h55AA55AA, 1'b0);
    wait_response(0);
    rst_n = 1'b0;
    #1;
    reset_checks("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NREG; k++) model_regs[k] = '0;
    exp_q.delete();
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (send_en) seen++;
    end
    check("no_send_after_reset", 256'(seen), 256'(0));
    send_frame(8'hA2, 8'h05, 8'h41, 32'h0, 1'b0); wait_response(1);
    check("scoreboard_empty", 256'(exp_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
